// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle layout and bubble value.
package id_ex_stage_pkg;

  localparam int CTRL_W        = 9;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_VALID    = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  // A bubble clears regwrite and valid, so it can never forward or stall.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in ID/EX.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       uses_rs1_id,
  input  logic       uses_rs2_id,
  input  logic [4:0] rd_idex,
  input  logic       memread_idex,
  input  logic       valid_idex,
  output logic       hazard
);

  logic src1_hit;
  logic src2_hit;

  // A load targeting x0 never stalls; only sources really read can match.
  always_comb begin
    src1_hit = uses_rs1_id && (rs1_id == rd_idex);
    src2_hit = uses_rs2_id && (rs2_id == rd_idex);
    hazard   = memread_idex && valid_idex && (rd_idex != 5'd0) && (src1_hit || src2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and debug counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic [4:0]        rd_id,
  input  logic              uses_rs1_id,
  input  logic              uses_rs2_id,
  input  logic [XLEN-1:0]   rdata1_id,
  input  logic [XLEN-1:0]   rdata2_id,
  input  logic [XLEN-1:0]   imm_id,
  input  logic [XLEN-1:0]   pc_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              flush_ex,
  output logic [4:0]        rs1_idex,
  output logic [4:0]        rs2_idex,
  output logic [4:0]        rd_idex,
  output logic [XLEN-1:0]   rdata1_idex,
  output logic [XLEN-1:0]   rdata2_idex,
  output logic [XLEN-1:0]   imm_idex,
  output logic [XLEN-1:0]   pc_idex,
  output logic [CTRL_W-1:0] ctrl_idex,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic hazard;
  logic stall;
  logic bubble;

  hazard_detect u_hazard_detect (
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .uses_rs1_id  (uses_rs1_id),
    .uses_rs2_id  (uses_rs2_id),
    .rd_idex      (rd_idex),
    .memread_idex (ctrl_idex[CTRL_MEMREAD]),
    .valid_idex   (ctrl_idex[CTRL_VALID]),
    .hazard       (hazard)
  );

  // A flush kills the ID instruction, so a coincident hazard must not freeze the front end.
  always_comb begin
    stall      = hazard && !flush_ex;
    bubble     = flush_ex || hazard;
    pc_write   = !stall;
    ifid_write = !stall;
  end

  // Pipeline register: bubble on flush or stall, otherwise capture ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_idex    <= '0;
      rs2_idex    <= '0;
      rd_idex     <= '0;
      rdata1_idex <= '0;
      rdata2_idex <= '0;
      imm_idex    <= '0;
      pc_idex     <= '0;
      ctrl_idex   <= CTRL_BUBBLE;
    end else if (bubble) begin
      rs1_idex    <= '0;
      rs2_idex    <= '0;
      rd_idex     <= '0;
      rdata1_idex <= '0;
      rdata2_idex <= '0;
      imm_idex    <= '0;
      pc_idex     <= '0;
      ctrl_idex   <= CTRL_BUBBLE;
    end else begin
      rs1_idex    <= rs1_id;
      rs2_idex    <= rs2_id;
      rd_idex     <= rd_id;
      rdata1_idex <= rdata1_id;
      rdata2_idex <= rdata2_id;
      imm_idex    <= imm_id;
      pc_idex     <= pc_id;
      ctrl_idex   <= ctrl_id;
    end
  end

  // Saturating event counters for stalls taken and flushes seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ex && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage against a transaction-level reference model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4:0]        rs1_id, rs2_id, rd_id;
  logic              uses_rs1_id, uses_rs2_id;
  logic [XLEN-1:0]   rdata1_id, rdata2_id, imm_id, pc_id;
  logic [CTRL_W-1:0] ctrl_id;
  logic              flush_ex;

  logic [4:0]        rs1_idex, rs2_idex, rd_idex;
  logic [XLEN-1:0]   rdata1_idex, rdata2_idex, imm_idex, pc_idex;
  logic [CTRL_W-1:0] ctrl_idex;
  logic              pc_write, ifid_write;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  logic [4:0]        s_rs1_idex, s_rs2_idex, s_rd_idex;
  logic [XLEN-1:0]   s_rdata1_idex, s_rdata2_idex, s_imm_idex, s_pc_idex;
  logic [CTRL_W-1:0] s_ctrl_idex;
  logic              s_pc_write, s_ifid_write;
  logic [SAT_W-1:0]  s_stall_cnt, s_flush_cnt;

  // reference model state
  logic [4:0]        m_rs1, m_rs2, m_rd;
  logic [XLEN-1:0]   m_d1, m_d2, m_imm, m_pc;
  logic [CTRL_W-1:0] m_ctrl;
  int unsigned       m_stall_ev, m_flush_ev;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id), .pc_id(pc_id),
    .ctrl_id(ctrl_id), .flush_ex(flush_ex),
    .rs1_idex(rs1_idex), .rs2_idex(rs2_idex), .rd_idex(rd_idex),
    .rdata1_idex(rdata1_idex), .rdata2_idex(rdata2_idex), .imm_idex(imm_idex), .pc_idex(pc_idex),
    .ctrl_idex(ctrl_idex), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // narrow-counter copy sharing the same stimulus, for cheap saturation coverage
  id_ex_stage #(.XLEN(XLEN), .CNT_W(SAT_W)) sat_dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id), .pc_id(pc_id),
    .ctrl_id(ctrl_id), .flush_ex(flush_ex),
    .rs1_idex(s_rs1_idex), .rs2_idex(s_rs2_idex), .rd_idex(s_rd_idex),
    .rdata1_idex(s_rdata1_idex), .rdata2_idex(s_rdata2_idex), .imm_idex(s_imm_idex), .pc_idex(s_pc_idex),
    .ctrl_idex(s_ctrl_idex), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic int unsigned sat(input int unsigned ev, input int w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (ev > mx) ? mx : ev;
  endfunction

  // load in ID/EX whose destination is read by the instruction in ID
  function automatic logic model_hazard();
    return m_ctrl[CTRL_MEMREAD] && m_ctrl[CTRL_VALID] && (m_rd != 5'd0) &&
           ((uses_rs1_id && (rs1_id == m_rd)) || (uses_rs2_id && (rs2_id == m_rd)));
  endfunction

  task automatic model_clear();
    m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0; m_pc = '0;
    m_ctrl = '0;
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic [CTRL_W-1:0] c,
                       input logic fl);
    rs1_id = r1; rs2_id = r2; rd_id = rd;
    uses_rs1_id = u1; uses_rs2_id = u2;
    ctrl_id = c; flush_ex = fl;
    rdata1_id = $urandom; rdata2_id = $urandom; imm_id = $urandom; pc_id = $urandom;
  endtask

  // One clock: check front-end enables, advance the model at the edge, check registers.
  task automatic do_cycle(input string tag);
    logic h;
    logic exp_w;
    logic [23:0]  exp_a, act_a, sat_a;
    logic [127:0] exp_d, act_d, sat_d;
    #1;
    h = model_hazard();
    exp_w = !(h && !flush_ex);
    n_total++;
    if ({pc_write, ifid_write, s_pc_write, s_ifid_write} !== {4{exp_w}})
      $display("FAIL %s enables: got pc_write=%b ifid_write=%b sat=%b%b expected %b",
               tag, pc_write, ifid_write, s_pc_write, s_ifid_write, exp_w);
    else n_pass++;
    @(posedge clk);
    if (flush_ex) begin
      m_flush_ev++;
      model_clear();
    end else if (h) begin
      m_stall_ev++;
      model_clear();
    end else begin
      m_rs1 = rs1_id; m_rs2 = rs2_id; m_rd = rd_id;
      m_d1 = rdata1_id; m_d2 = rdata2_id; m_imm = imm_id; m_pc = pc_id;
      m_ctrl = ctrl_id;
    end
    #1;
    exp_a = {m_rs1, m_rs2, m_rd, m_ctrl};
    act_a = {rs1_idex, rs2_idex, rd_idex, ctrl_idex};
    sat_a = {s_rs1_idex, s_rs2_idex, s_rd_idex, s_ctrl_idex};
    exp_d = {m_d1, m_d2, m_imm, m_pc};
    act_d = {rdata1_idex, rdata2_idex, imm_idex, pc_idex};
    sat_d = {s_rdata1_idex, s_rdata2_idex, s_imm_idex, s_pc_idex};
    n_total++;
    if (act_a !== exp_a || sat_a !== exp_a)
      $display("FAIL %s addr/ctrl: got %h (sat %h) expected %h", tag, act_a, sat_a, exp_a);
    else n_pass++;
    n_total++;
    if (act_d !== exp_d || sat_d !== exp_d)
      $display("FAIL %s data: got %h expected %h", tag, act_d, exp_d);
    else n_pass++;
    n_total++;
    if (32'(stall_cnt) !== sat(m_stall_ev, CNT_W) || 32'(flush_cnt) !== sat(m_flush_ev, CNT_W))
      $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d", tag,
               stall_cnt, flush_cnt, sat(m_stall_ev, CNT_W), sat(m_flush_ev, CNT_W));
    else n_pass++;
    n_total++;
    if (32'(s_stall_cnt) !== sat(m_stall_ev, SAT_W) || 32'(s_flush_cnt) !== sat(m_flush_ev, SAT_W))
      $display("FAIL %s narrow counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d", tag,
               s_stall_cnt, s_flush_cnt, sat(m_stall_ev, SAT_W), sat(m_flush_ev, SAT_W));
    else n_pass++;
  endtask

  localparam logic [CTRL_W-1:0] C_ADD  = (CTRL_W'(1) << CTRL_REGWRITE) | (CTRL_W'(1) << CTRL_VALID);
  localparam logic [CTRL_W-1:0] C_LOAD = C_ADD | (CTRL_W'(1) << CTRL_MEMREAD) |
                                         (CTRL_W'(1) << CTRL_MEMTOREG) | (CTRL_W'(1) << CTRL_ALUSRC);

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, '0, 1'b0);
    model_clear();
    m_stall_ev = 0; m_flush_ev = 0;
    #12;
    n_total++;
    if ({rs1_idex, rs2_idex, rd_idex, ctrl_idex, rdata1_idex, rdata2_idex, imm_idex, pc_idex,
         stall_cnt, flush_cnt} !== '0)
      $display("FAIL reset_state: got ctrl=%h rd=%0d stall=%0d flush=%0d expected all zero",
               ctrl_idex, rd_idex, stall_cnt, flush_cnt);
    else n_pass++;
    n_total++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1)
      $display("FAIL reset_enables: got %b%b expected 11", pc_write, ifid_write);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal_capture();
    drive(5'd3, 5'd4, 5'd6, 1'b1, 1'b1, C_ADD, 1'b0);
    rdata1_id = 32'h1234;
    do_cycle("normal");
    n_total++;
    if (rs1_idex !== 5'd3 || rdata1_idex !== 32'h1234 || ctrl_idex !== C_ADD || pc_write !== 1'b1)
      $display("FAIL normal_direct: got rs1=%0d rdata1=%h ctrl=%h pc_write=%b expected 3 1234 %h 1",
               rs1_idex, rdata1_idex, ctrl_idex, pc_write, C_ADD);
    else n_pass++;
  endtask

  task automatic test_load_use();
    int unsigned st0;
    drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, C_LOAD, 1'b0);
    do_cycle("lu_load");
    st0 = 32'(stall_cnt);
    drive(5'd8, 5'd5, 5'd9, 1'b1, 1'b1, C_ADD, 1'b0);
    #1;
    n_total++;
    if (pc_write !== 1'b0 || ifid_write !== 1'b0)
      $display("FAIL load_use_freeze: got %b%b expected 00", pc_write, ifid_write);
    else n_pass++;
    do_cycle("lu_stall");
    n_total++;
    if (ctrl_idex !== '0 || 32'(stall_cnt) !== st0 + 1)
      $display("FAIL load_use_bubble: got ctrl=%h stall=%0d expected 0 %0d", ctrl_idex, stall_cnt, st0 + 1);
    else n_pass++;
    do_cycle("lu_resume");
    n_total++;
    if (rs2_idex !== 5'd5 || ctrl_idex !== C_ADD)
      $display("FAIL load_use_resume: got rs2=%0d ctrl=%h expected 5 %h", rs2_idex, ctrl_idex, C_ADD);
    else n_pass++;
  endtask

  task automatic test_no_false_stall();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_LOAD, 1'b0);
    do_cycle("x0_load");
    drive(5'd0, 5'd3, 5'd4, 1'b1, 1'b1, C_ADD, 1'b0);
    #1;
    n_total++;
    if (pc_write !== 1'b1) $display("FAIL x0_no_stall: got pc_write=%b expected 1", pc_write);
    else n_pass++;
    do_cycle("x0_dep");
    drive(5'd1, 5'd1, 5'd7, 1'b0, 1'b0, C_LOAD, 1'b0);
    do_cycle("unused_load");
    drive(5'd2, 5'd7, 5'd3, 1'b1, 1'b0, C_ADD, 1'b0);
    #1;
    n_total++;
    if (ifid_write !== 1'b1) $display("FAIL unused_src_no_stall: got ifid_write=%b expected 1", ifid_write);
    else n_pass++;
    do_cycle("unused_dep");
  endtask

  task automatic test_flush_hazard();
    int unsigned st0, fl0;
    drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, C_LOAD, 1'b0);
    do_cycle("fh_load");
    st0 = 32'(stall_cnt); fl0 = 32'(flush_cnt);
    drive(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, C_ADD, 1'b1);
    do_cycle("fh_both");
    n_total++;
    if (ctrl_idex !== '0 || 32'(flush_cnt) !== fl0 + 1 || 32'(stall_cnt) !== st0)
      $display("FAIL flush_hazard: got ctrl=%h flush=%0d stall=%0d expected 0 %0d %0d",
               ctrl_idex, flush_cnt, stall_cnt, fl0 + 1, st0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [CTRL_W-1:0] c;
    for (int i = 0; i < 400; i++) begin
      c = CTRL_W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        c[CTRL_MEMREAD] = 1'b1;
        c[CTRL_VALID]   = 1'b1;
      end
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), c, ($urandom_range(0, 7) == 0));
      do_cycle("random");
    end
  endtask

  task automatic test_back_to_back_loads();
    drive(5'd1, 5'd2, 5'd10, 1'b1, 1'b1, C_LOAD, 1'b0);
    do_cycle("b2b_load1");
    drive(5'd10, 5'd2, 5'd11, 1'b1, 1'b0, C_LOAD, 1'b0);
    do_cycle("b2b_stall1");
    do_cycle("b2b_load2");
    drive(5'd3, 5'd11, 5'd12, 1'b0, 1'b1, C_ADD, 1'b0);
    do_cycle("b2b_stall2");
    do_cycle("b2b_add");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, C_LOAD, 1'b0);
      do_cycle("sat_load");
      drive(5'd9, 5'd2, 5'd3, 1'b1, 1'b0, C_ADD, 1'b0);
      do_cycle("sat_stall");
    end
    for (int i = 0; i < 20; i++) begin
      drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_ADD, 1'b1);
      do_cycle("sat_flush");
    end
    n_total++;
    if (s_stall_cnt !== 4'hF || s_flush_cnt !== 4'hF)
      $display("FAIL saturation_hold: got stall=%h flush=%h expected f f", s_stall_cnt, s_flush_cnt);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(5'd1, 5'd2, 5'd13, 1'b1, 1'b1, C_LOAD, 1'b0);
    do_cycle("ar_load");
    drive(5'd13, 5'd13, 5'd4, 1'b1, 1'b1, C_ADD, 1'b0);
    #1;
    n_total++;
    if (pc_write !== 1'b0) $display("FAIL async_pre_hazard: got pc_write=%b expected 0", pc_write);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({rs1_idex, rs2_idex, rd_idex, ctrl_idex, rdata1_idex, rdata2_idex, imm_idex, pc_idex,
         stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt} !== '0)
      $display("FAIL async_reset_clear: got ctrl=%h rd=%0d stall=%0d flush=%0d expected all zero",
               ctrl_idex, rd_idex, stall_cnt, flush_cnt);
    else n_pass++;
    n_total++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1)
      $display("FAIL async_reset_enables: got %b%b expected 11", pc_write, ifid_write);
    else n_pass++;
    model_clear();
    m_stall_ev = 0; m_flush_ev = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle("ar_after");
  endtask

  initial begin
    test_reset();
    test_normal_capture();
    test_load_use();
    test_no_false_stall();
    test_flush_hazard();
    test_back_to_back_loads();
    test_random();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
